mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port to one-port memory arbiter placed between the pipeline and a single unified memory. It accepts the pipeline's instruction-fetch bus and data-memory bus and serializes their transactions onto one request/acknowledge memory port. Arbitration is round-robin, in-flight fetches can be abandoned, and a watchdog counter aborts transactions the memory never acknowledges.

## Interface
- TIMEOUT, 255: maximum cycles `mem_req` stays high before abort; range 1–65535.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- imem_addr  in  64  fetch address; sampled at grant.
- imem_addr_valid  in  1  fetch request, level; dropping it cancels the fetch.
- imem_data  out  64  fetch data; registered.
- imem_data_valid  out  1  one-cycle fetch completion pulse.
- dmem_addr  in  64  data address; sampled at grant.
- dmem_dout  in  64  store data from the pipeline; sampled at grant.
- dmem_din  out  64  load data to the pipeline; registered.
- dmem_write_width  in  2  access width: 0=8b, 1=16b, 2=32b, 3=64b.
- dmem_rstrobe / dmem_wstrobe  in  1  read/write request, level, held until `dmem_cycle_complete`. Both high is illegal.
- dmem_cycle_complete  out  1  one-cycle data completion pulse.
- mem_addr  out  64, mem_wdata  out  64, mem_width  out  2, mem_we  out  1: downstream command, registered, stable while `mem_req`=1.
- mem_req  out  1  downstream request, level.
- mem_rdata  in  64  read data; valid when `mem_ack`=1.
- mem_ack  in  1  one-cycle acknowledge; legal from the first cycle `mem_req`=1.
- bus_error  out  1  sticky timeout flag; cleared only by `rst`.

## Operation
- States: IDLE, IGNT, DGNT, RESP. Reset state is IDLE.
- Reset values: all outputs 0; `last_d`=1, so the first contended grant goes to instruction; `icancel`=0; watchdog=0.
- IDLE transitions:
  - `ireq=imem_addr_valid`, `dreq=dmem_rstrobe|dmem_wstrobe`.
  - Only `ireq` → IGNT. Only `dreq` → DGNT. Both → the port not served last (`last_d`=1 → IGNT, else DGNT).
  - On entering a grant state, register the command:
    - IGNT: `mem_addr`=imem_addr, `mem_we`=0, `mem_width`=3, `mem_wdata`=0.
    - DGNT: `mem_addr`=dmem_addr, `mem_we`=dmem_wstrobe, `mem_width`=dmem_write_width, `mem_wdata`=dmem_dout.
    - Set `mem_req`=1 and clear the watchdog.
- IGNT/DGNT hold the command, increment the watchdog each cycle, and wait for `mem_ack`:
  - On `mem_ack`: `mem_req`←0 and go to RESP.
    - IGNT: `imem_data`←mem_rdata; `imem_data_valid`←~icancel; `last_d`←0.
    - DGNT: `dmem_din`←mem_rdata (write: `dmem_din` is still loaded, value is don't-care); `dmem_cycle_complete`←1; `last_d`←1.
  - Watchdog reaching TIMEOUT with no ack: `mem_req`←0, `bus_error`←1, returned data = 64'hFFFF_FFFF_FFFF_FFFF. Completion pulses and `last_d` update exactly as for an ack.
- Fetch cancel: `imem_addr_valid`=0 in any IGNT cycle sets `icancel`. The transaction still completes downstream; its data is discarded with no `imem_data_valid`. `icancel` clears in RESP.
- RESP lasts one cycle. The completion pulse is high in this cycle, both request inputs are ignored (the requester is dropping its request), and the pulse returns to 0. Next state is IDLE.
- `mem_ack` outside IGNT/DGNT is ignored.

## Timing
- Requests are sampled in IDLE at edge E. `mem_req`=1 from E+1.
- With `mem_ack` in cycle E+1, the completion pulse and data are out in E+2 (RESP), and the next grant is decided in E+3 (IDLE). The minimum period is 3 cycles per transaction; latency is 2 cycles plus ack wait.
- Address and data are captured at grant. Input changes after grant have no effect on the current transaction.
- Asynchronous `rst` mid-transaction:
  - Immediately drops `mem_req` and zeroes all outputs.
  - The outstanding downstream transaction is abandoned. A late `mem_ack` after reset is ignored, because the state is IDLE.
- Watchdog width is ceil(log2(TIMEOUT+1)) bits; it saturates and never wraps.

## Test plan
- Single fetch, addr 0x1000, memory acks in the first req cycle with rdata 0xDEADBEEF → `mem_req` high for 1 cycle, `mem_we`=0, `mem_width`=3; `imem_data_valid` pulses 2 cycles after the request with `imem_data`=0xDEADBEEF.
- Write, addr 0x2008, width 2, dout 0x55, ack after 3 cycles → `mem_we`=1, `mem_wdata`=0x55, `mem_width`=2 held for 3 cycles; one `dmem_cycle_complete` pulse; no `imem_data_valid`.
- Fetch and read held together continuously from reset → grants alternate I, D, I, D; no port is granted twice in a row while the other is pending.
- Fetch granted, `imem_addr_valid` dropped in the next cycle, ack 2 cycles later → `imem_data_valid` stays 0 throughout; the arbiter returns to IDLE and serves a subsequent read normally.
- TIMEOUT=4, memory never acks a read → `mem_req` falls after 4 cycles, `bus_error`=1 and stays 1, `dmem_din`=all ones, one completion pulse; a later ack is ignored.
- `rst` asserted while in DGNT → `mem_req`, `dmem_cycle_complete` and `bus_error` go 0 asynchronously; after release, the first contended grant goes to instruction.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter serializing fetch and data buses onto one
// request/acknowledge memory port, with fetch cancel and a timeout watchdog.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] imem_addr,
    input  logic        imem_addr_valid,
    output logic [63:0] imem_data,
    output logic        imem_data_valid,
    input  logic [63:0] dmem_addr,
    input  logic [63:0] dmem_dout,
    output logic [63:0] dmem_din,
    input  logic [1:0]  dmem_write_width,
    input  logic        dmem_rstrobe,
    input  logic        dmem_wstrobe,
    output logic        dmem_cycle_complete,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [1:0]  mem_width,
    output logic        mem_we,
    output logic        mem_req,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_error
);
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, IGNT, DGNT, RESP} state_t;

    state_t           state_q, state_d;
    logic [WDW-1:0]   wd_q, wd_d;
    logic             last_dmem_q, last_dmem_d;
    logic             icancel_q, icancel_d;
    logic [63:0]      imem_data_q, imem_data_d;
    logic             imem_data_valid_q, imem_data_valid_d;
    logic [63:0]      dmem_din_q, dmem_din_d;
    logic             dmem_cycle_complete_q, dmem_cycle_complete_d;
    logic [63:0]      mem_addr_q, mem_addr_d;
    logic [63:0]      mem_wdata_q, mem_wdata_d;
    logic [1:0]       mem_width_q, mem_width_d;
    logic             mem_we_q, mem_we_d;
    logic             mem_req_q, mem_req_d;
    logic             bus_error_q, bus_error_d;

    always_comb begin
        logic        ireq;
        logic        dreq;
        logic        done;
        logic        cancel;
        logic [63:0] rdata;
        state_d               = state_q;
        wd_d                  = wd_q;
        last_dmem_d           = last_dmem_q;
        icancel_d             = icancel_q;
        imem_data_d           = imem_data_q;
        imem_data_valid_d     = 1'b0;
        dmem_din_d            = dmem_din_q;
        dmem_cycle_complete_d = 1'b0;
        mem_addr_d            = mem_addr_q;
        mem_wdata_d           = mem_wdata_q;
        mem_width_d           = mem_width_q;
        mem_we_d              = mem_we_q;
        mem_req_d             = mem_req_q;
        bus_error_d           = bus_error_q;
        ireq   = imem_addr_valid;
        dreq   = dmem_rstrobe | dmem_wstrobe;
        done   = mem_ack | (wd_q >= WDW'(TIMEOUT - 1));
        rdata  = mem_ack ? mem_rdata : '1;
        cancel = icancel_q | ((state_q == IGNT) & ~imem_addr_valid);
        case (state_q)
            IDLE: begin
                if (ireq || dreq) begin
                    // contended requests go to whichever port was not served last
                    if (ireq && (!dreq || last_dmem_q)) begin
                        state_d     = IGNT;
                        mem_addr_d  = imem_addr;
                        mem_we_d    = 1'b0;
                        mem_width_d = 2'd3;
                        mem_wdata_d = '0;
                    end else begin
                        state_d     = DGNT;
                        mem_addr_d  = dmem_addr;
                        mem_we_d    = dmem_wstrobe;
                        mem_width_d = dmem_write_width;
                        mem_wdata_d = dmem_dout;
                    end
                    mem_req_d = 1'b1;
                    wd_d      = '0;
                end
            end
            IGNT, DGNT: begin
                wd_d = (&wd_q) ? wd_q : wd_q + WDW'(1);
                if (state_q == IGNT)
                    icancel_d = cancel;
                if (done) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    bus_error_d = bus_error_q | ~mem_ack;
                    if (state_q == IGNT) begin
                        imem_data_d       = rdata;
                        imem_data_valid_d = ~cancel;
                        last_dmem_d       = 1'b0;
                    end else begin
                        dmem_din_d            = rdata;
                        dmem_cycle_complete_d = 1'b1;
                        last_dmem_d           = 1'b1;
                    end
                end
            end
            RESP: begin
                icancel_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q               <= IDLE;
            wd_q                  <= '0;
            last_dmem_q           <= 1'b1;
            icancel_q             <= 1'b0;
            imem_data_q           <= '0;
            imem_data_valid_q     <= 1'b0;
            dmem_din_q            <= '0;
            dmem_cycle_complete_q <= 1'b0;
            mem_addr_q            <= '0;
            mem_wdata_q           <= '0;
            mem_width_q           <= '0;
            mem_we_q              <= 1'b0;
            mem_req_q             <= 1'b0;
            bus_error_q           <= 1'b0;
        end else begin
            state_q               <= state_d;
            wd_q                  <= wd_d;
            last_dmem_q           <= last_dmem_d;
            icancel_q             <= icancel_d;
            imem_data_q           <= imem_data_d;
            imem_data_valid_q     <= imem_data_valid_d;
            dmem_din_q            <= dmem_din_d;
            dmem_cycle_complete_q <= dmem_cycle_complete_d;
            mem_addr_q            <= mem_addr_d;
            mem_wdata_q           <= mem_wdata_d;
            mem_width_q           <= mem_width_d;
            mem_we_q              <= mem_we_d;
            mem_req_q             <= mem_req_d;
            bus_error_q           <= bus_error_d;
        end
    end

    assign imem_data           = imem_data_q;
    assign imem_data_valid     = imem_data_valid_q;
    assign dmem_din            = dmem_din_q;
    assign dmem_cycle_complete = dmem_cycle_complete_q;
    assign mem_addr            = mem_addr_q;
    assign mem_wdata           = mem_wdata_q;
    assign mem_width           = mem_width_q;
    assign mem_we              = mem_we_q;
    assign mem_req             = mem_req_q;
    assign bus_error           = bus_error_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus against a transaction-level model of the
// arbiter, compared every cycle, plus hand-computed literal expectations.
module tb_mem_arbiter;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] imem_addr, dmem_addr, dmem_dout, mem_rdata;
    logic        imem_addr_valid, dmem_rstrobe, dmem_wstrobe, mem_ack;
    logic [1:0]  dmem_write_width;
    logic [63:0] imem_data, dmem_din, mem_addr, mem_wdata;
    logic        imem_data_valid, dmem_cycle_complete, mem_we, mem_req, bus_error;
    logic [1:0]  mem_width;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_addr_valid(imem_addr_valid),
        .imem_data(imem_data), .imem_data_valid(imem_data_valid),
        .dmem_addr(dmem_addr), .dmem_dout(dmem_dout), .dmem_din(dmem_din),
        .dmem_write_width(dmem_write_width),
        .dmem_rstrobe(dmem_rstrobe), .dmem_wstrobe(dmem_wstrobe),
        .dmem_cycle_complete(dmem_cycle_complete),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_width(mem_width),
        .mem_we(mem_we), .mem_req(mem_req),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: ack in the ack_wait-th cycle of a request (0 = never)
    int          ack_wait = 1;
    int          rc = 0;
    logic        stray = 1'b0;
    logic [63:0] rdata_val = '0;
    always @(posedge clk) begin
        #2;
        mem_rdata = rdata_val;
        if (mem_req) begin
            rc = rc + 1;
            mem_ack = (ack_wait != 0) && (rc == ack_wait);
        end else begin
            rc = 0;
            mem_ack = stray;
        end
    end

    // Transaction-level model: phase 0 idle, 1 waiting on memory, 2 reporting
    int          phase, age;
    bit          port_d, cancel, served_d;
    logic [63:0] m_data;
    logic        e_req, e_we, e_idv, e_dcc, e_berr;
    logic [63:0] e_addr, e_wdata, e_idata, e_ddin;
    logic [1:0]  e_width;
    logic [63:0] m_grants[$];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase = 0; age = 0; cancel = 0; served_d = 1; port_d = 0;
            e_req = 0; e_we = 0; e_idv = 0; e_dcc = 0; e_berr = 0;
            e_addr = 0; e_wdata = 0; e_idata = 0; e_ddin = 0; e_width = 0;
        end else begin
            e_idv = 0;
            e_dcc = 0;
            if (phase == 2) begin
                phase = 0;
                cancel = 0;
            end else if (phase == 1) begin
                age++;
                if (!port_d && !imem_addr_valid) cancel = 1;
                if (mem_ack || age == TO) begin
                    m_data = mem_ack ? mem_rdata : 64'hFFFF_FFFF_FFFF_FFFF;
                    if (!mem_ack) e_berr = 1;
                    e_req = 0;
                    phase = 2;
                    served_d = port_d;
                    if (port_d) begin e_ddin = m_data; e_dcc = 1; end
                    else begin e_idata = m_data; e_idv = !cancel; end
                end
            end else if (imem_addr_valid || dmem_rstrobe || dmem_wstrobe) begin
                port_d = !(imem_addr_valid && (!(dmem_rstrobe || dmem_wstrobe) || served_d));
                e_addr  = port_d ? dmem_addr : imem_addr;
                e_we    = port_d ? dmem_wstrobe : 1'b0;
                e_width = port_d ? dmem_write_width : 2'd3;
                e_wdata = port_d ? dmem_dout : 64'd0;
                e_req = 1;
                age = 0;
                phase = 1;
                m_grants.push_back(e_addr);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("mem_req", mem_req, e_req);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_we", mem_we, e_we);
            chk("mem_width", mem_width, e_width);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("imem_data_valid", imem_data_valid, e_idv);
            chk("imem_data", imem_data, e_idata);
            chk("dmem_cycle_complete", dmem_cycle_complete, e_dcc);
            chk("dmem_din", dmem_din, e_ddin);
            chk("bus_error", bus_error, e_berr);
        end
    end

    logic        prev_req = 1'b0;
    logic [63:0] d_grants[$];
    always @(negedge clk) begin
        if (mem_req && !prev_req) d_grants.push_back(mem_addr);
        prev_req = mem_req;
    end

    logic [63:0] exp_g [4];

    initial begin
        rst = 1; imem_addr = 0; imem_addr_valid = 0; dmem_addr = 0; dmem_dout = 0;
        dmem_write_width = 0; dmem_rstrobe = 0; dmem_wstrobe = 0; mem_ack = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset mem_req", mem_req, 0);
        chk("reset bus_error", bus_error, 0);
        chk("reset imem_data_valid", imem_data_valid, 0);

        // single fetch, ack in first request cycle
        rdata_val = 64'hDEADBEEF; ack_wait = 1;
        imem_addr = 64'h1000; imem_addr_valid = 1;
        tick();
        @(negedge clk);
        chk("fetch mem_req", mem_req, 1);
        chk("fetch mem_width", mem_width, 3);
        chk("fetch mem_addr", mem_addr, 64'h1000);
        tick();
        imem_addr_valid = 0;
        @(negedge clk);
        chk("fetch valid", imem_data_valid, 1);
        chk("fetch data", imem_data, 64'hDEADBEEF);
        tick();

        // write, ack in third request cycle
        ack_wait = 3; dmem_addr = 64'h2008; dmem_write_width = 2; dmem_dout = 64'h55; dmem_wstrobe = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("write mem_we", mem_we, 1);
            chk("write mem_wdata", mem_wdata, 64'h55);
            chk("write mem_width", mem_width, 2);
            tick();
        end
        dmem_wstrobe = 0;
        @(negedge clk);
        chk("write complete", dmem_cycle_complete, 1);
        chk("write no fetch valid", imem_data_valid, 0);
        tick();

        // fetch and read held together: grants alternate
        ack_wait = 1; rdata_val = 64'h77;
        imem_addr = 64'h3000; dmem_addr = 64'h4000; imem_addr_valid = 1; dmem_rstrobe = 1;
        d_grants.delete(); m_grants.delete();
        repeat (11) tick();
        imem_addr_valid = 0; dmem_rstrobe = 0;
        tick();
        exp_g = '{64'h3000, 64'h4000, 64'h3000, 64'h4000};
        chk("grant count", d_grants.size(), 4);
        chk("model grant count", m_grants.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("grant order", (i < d_grants.size()) ? d_grants[i] : 64'hx, exp_g[i]);
            chk("model grant order", (i < m_grants.size()) ? m_grants[i] : 64'hx, exp_g[i]);
        end

        // cancelled fetch, then a normal read
        ack_wait = 3; rdata_val = 64'hABCD;
        imem_addr = 64'h5000; imem_addr_valid = 1;
        tick();
        tick();
        imem_addr_valid = 0;
        tick();
        tick();
        @(negedge clk);
        chk("cancel no valid", imem_data_valid, 0);
        tick();
        ack_wait = 1; rdata_val = 64'h1234; dmem_addr = 64'h6000; dmem_rstrobe = 1;
        tick();
        tick();
        dmem_rstrobe = 0;
        @(negedge clk);
        chk("post-cancel read complete", dmem_cycle_complete, 1);
        chk("post-cancel read data", dmem_din, 64'h1234);
        tick();

        // watchdog timeout on a read
        ack_wait = 0; dmem_addr = 64'h7000; dmem_rstrobe = 1;
        tick();
        repeat (3) tick();
        @(negedge clk);
        chk("timeout req held", mem_req, 1);
        tick();
        dmem_rstrobe = 0;
        @(negedge clk);
        chk("timeout req dropped", mem_req, 0);
        chk("timeout bus_error", bus_error, 1);
        chk("timeout data", dmem_din, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("timeout complete", dmem_cycle_complete, 1);
        tick();
        stray = 1;
        tick();
        stray = 0;
        @(negedge clk);
        chk("sticky bus_error", bus_error, 1);
        chk("stray ack no complete", dmem_cycle_complete, 0);
        tick();

        // asynchronous reset during a data grant
        dmem_addr = 64'h8000; dmem_rstrobe = 1;
        tick();
        #2 rst = 1;
        #1;
        chk("rst mem_req", mem_req, 0);
        chk("rst complete", dmem_cycle_complete, 0);
        chk("rst bus_error", bus_error, 0);
        chk("rst mem_addr", mem_addr, 0);
        dmem_rstrobe = 0;
        @(posedge clk);
        #1 rst = 0;
        stray = 1;
        tick();
        stray = 0; ack_wait = 1; rdata_val = 64'h99;
        imem_addr = 64'h9000; dmem_addr = 64'hA000; imem_addr_valid = 1; dmem_rstrobe = 1;
        tick();
        @(negedge clk);
        chk("post-rst grant to fetch", mem_addr, 64'h9000);
        tick();
        imem_addr_valid = 0; dmem_rstrobe = 0;
        @(negedge clk);
        chk("post-rst fetch valid", imem_data_valid, 1);
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
